// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch stage: the canonical NOP encoding and
// the two fetch-stage FSM states.
package riscv_pkg;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    FS_BOOT = 1'b0,
    FS_RUN  = 1'b1
  } fetch_state_e;

endpackage : riscv_pkg

// File: rtl/fetch_stage.sv
// Instruction fetch stage. Owns the PC and drives a synchronous-read
// instruction memory. imem_addr_o carries the next PC so that the word
// arriving on imem_data_i always belongs to the current PC (pc_q).
//
// Downstream handshake: valid_o qualifies instr_o/pc_o/pc4_o/fault_o for the
// current cycle; the IF/ID register takes the instruction on an edge where
// valid_o=1 and stall_i=0, and only such edges advance fetch_cnt_o. While
// stall_i=1 the same PC is re-presented, so the outputs hold steady.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 65536
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc4_o,
  output logic        valid_o,
  output logic        fault_o,
  output logic [31:0] fetch_cnt_o
);

  // Highest word-aligned PC whose full word lies inside imem.
  localparam logic [31:0] PC_MAX = 32'(IMEM_BYTES - 4);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  fetch_cnt_q, fetch_cnt_d;
  logic [31:0]  pc_plus4;
  logic         fault_cond;

  // Single adder shared by the sequential next PC and pc4_o.
  assign pc_plus4   = pc_q + 32'd4;
  assign fault_cond = (pc_q[1:0] != 2'b00) || (pc_q > PC_MAX);

  // Next-state, next-PC, counter and output decode.
  always_comb begin
    state_d     = FS_RUN;
    pc_d        = pc_plus4;
    fetch_cnt_d = fetch_cnt_q;
    valid_o     = 1'b0;
    fault_o     = 1'b0;
    instr_o     = NOP_INSTR;

    // Redirect beats stall; the boot cycle re-presents RESET_PC because the
    // memory output is still stale.
    if (redirect_valid_i) begin
      pc_d = redirect_pc_i;
    end else if (stall_i || (state_q == FS_BOOT)) begin
      pc_d = pc_q;
    end

    // The word fetched for the old path is squashed in the redirect cycle.
    if (state_q == FS_RUN) begin
      valid_o = !redirect_valid_i;
    end

    fault_o = valid_o && fault_cond;

    if (valid_o && !fault_o) begin
      instr_o = imem_data_i;
    end

    // Faulting instructions are still handed down; downstream traps on them.
    if (valid_o && !stall_i) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
  end

  // PC, FSM state and fetch counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= FS_BOOT;
      pc_q        <= RESET_PC;
      fetch_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  // A redirect presented while reset is held must not leak onto the bus.
  assign imem_addr_o = rst_i ? RESET_PC : pc_d;
  assign pc_o        = pc_q;
  assign pc4_o       = pc_plus4;
  assign fetch_cnt_o = fetch_cnt_q;

endmodule : fetch_stage
